// File: rtl/first_pack.sv
// Shared FIFO-side constants and the write arbiter's state encoding.
package first_pack;

   localparam int unsigned FIFO_WIDTH    = 16;
   localparam int unsigned max_fifo_addr = 15;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp,
      StRetry
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req after last_winner, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IdxW-1:0]    last_winner,
   output logic [IdxW-1:0]    winner,
   output logic               any_req
);

   logic [IdxW-1:0] idx;

   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = IdxW'((32'(last_winner) + i) % NUM_REQ);
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            winner  = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with overflow-driven retry of the same word and a sticky missing-response error.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned FIFO_WIDTH = first_pack::FIFO_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_REQ-1:0]                   req,
   input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]                   gnt,
   output logic                                 wr_en,
   output logic [FIFO_WIDTH-1:0]                data_in,
   input  logic                                 full,
   input  logic                                 wr_ack,
   input  logic                                 overflow,
   output logic [7:0]                           retry_cnt,
   output logic                                 err
);
   import first_pack::*;

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   arb_state_e            state_q, state_d;
   logic [IdxW-1:0]       winner_q, winner_d;
   logic [IdxW-1:0]       last_winner_q, last_winner_d;
   logic [FIFO_WIDTH-1:0] data_q, data_d;
   logic [7:0]            retry_q, retry_d;
   logic                  err_q, err_d;
   logic                  wr_en_q, wr_en_d;
   logic [IdxW-1:0]       pick;
   logic                  any_req;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IdxW    (IdxW)
   ) u_rr_pick (
      .req         (req),
      .last_winner (last_winner_q),
      .winner      (pick),
      .any_req     (any_req)
   );

   always_comb begin
      state_d       = state_q;
      winner_d      = winner_q;
      last_winner_d = last_winner_q;
      data_d        = data_q;
      retry_d       = retry_q;
      err_d         = err_q;
      wr_en_d       = 1'b0;
      gnt           = '0;
      unique case (state_q)
         StIdle: begin
            if (any_req && !full) begin
               winner_d = pick;
               data_d   = req_data[pick];
               wr_en_d  = 1'b1;
               state_d  = StIssue;
            end
         end
         StIssue: state_d = StResp;
         StResp: begin
            // wr_ack takes precedence; a simultaneous overflow is a protocol error
            if (wr_ack) begin
               gnt[winner_q] = 1'b1;
               last_winner_d = winner_q;
               state_d       = StIdle;
               if (overflow) err_d = 1'b1;
            end else if (overflow) begin
               if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
               state_d = StRetry;
            end else begin
               err_d   = 1'b1;
               state_d = StRetry;
            end
         end
         StRetry: begin
            if (!full) begin
               wr_en_d = 1'b1;
               state_d = StIssue;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         winner_q      <= '0;
         last_winner_q <= IdxW'(NUM_REQ - 1);
         data_q        <= '0;
         retry_q       <= '0;
         err_q         <= 1'b0;
         wr_en_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         winner_q      <= winner_d;
         last_winner_q <= last_winner_d;
         data_q        <= data_d;
         retry_q       <= retry_d;
         err_q         <= err_d;
         wr_en_q       <= wr_en_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign data_in   = data_q;
   assign retry_cnt = retry_q;
   assign err       = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single write, full stall, overflow retry,
// missing response, mid-transaction reset and round-robin ordering.
module tb_fifo_wr_arbiter;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [3:0]       req = '0;
   logic [3:0][15:0] req_data = '0;
   logic [3:0]       gnt;
   logic             wr_en;
   logic [15:0]      data_in;
   logic             full = 1'b0;
   logic             wr_ack = 1'b0;
   logic             overflow = 1'b0;
   logic [7:0]       retry_cnt;
   logic             err;

   int unsigned n_run  = 0;
   int unsigned n_fail = 0;
   logic        prev_en;
   int          last_c;
   int          ngnt;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ    (4),
      .FIFO_WIDTH (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .wr_en     (wr_en),
      .data_in   (data_in),
      .full      (full),
      .wr_ack    (wr_ack),
      .overflow  (overflow),
      .retry_cnt (retry_cnt),
      .err       (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_gnt", 32'(gnt), 0);
      check_eq("rst_wr_en", 32'(wr_en), 0);
      check_eq("rst_data_in", 32'(data_in), 0);
      check_eq("rst_retry", 32'(retry_cnt), 0);
      check_eq("rst_err", 32'(err), 0);

      // Single producer 2, arbitration on first edge after release
      req_data[2] = 16'hA5A5;
      req         = 4'b0100;
      rst_n       = 1'b1;
      @(negedge clk);
      check_eq("single_wr_en", 32'(wr_en), 1);
      check_eq("single_data", 32'(data_in), 32'hA5A5);
      check_eq("single_gnt_early", 32'(gnt), 0);
      @(negedge clk);
      wr_ack = 1'b1;
      #1;
      check_eq("single_gnt", 32'(gnt), 32'h4);
      check_eq("single_wr_en_resp", 32'(wr_en), 0);
      req = 4'b0000;
      @(negedge clk);
      wr_ack = 1'b0;
      #1;
      check_eq("single_gnt_done", 32'(gnt), 0);
      check_eq("single_wr_en_idle", 32'(wr_en), 0);

      // Full holds the arbiter in idle
      full        = 1'b1;
      req_data[1] = 16'h1234;
      req         = 4'b0010;
      repeat (3) @(negedge clk);
      check_eq("full_wr_en", 32'(wr_en), 0);
      check_eq("full_data_hold", 32'(data_in), 32'hA5A5);
      full = 1'b0;
      @(negedge clk);
      check_eq("unfull_wr_en", 32'(wr_en), 1);
      check_eq("unfull_data", 32'(data_in), 32'h1234);
      @(negedge clk);
      wr_ack = 1'b1;
      #1;
      check_eq("unfull_gnt", 32'(gnt), 32'h2);
      req = 4'b0000;
      @(negedge clk);
      wr_ack = 1'b0;

      // Overflow on producer 3: retry same word, no re-arbitration
      req_data[3] = 16'h3C3C;
      req         = 4'b1000;
      @(negedge clk);
      check_eq("ovf_wr_en", 32'(wr_en), 1);
      check_eq("ovf_data", 32'(data_in), 32'h3C3C);
      @(negedge clk);
      overflow = 1'b1;
      full     = 1'b1;
      #1;
      check_eq("ovf_gnt", 32'(gnt), 0);
      @(negedge clk);
      overflow = 1'b0;
      check_eq("ovf_retry_cnt", 32'(retry_cnt), 1);
      check_eq("ovf_retry_wr_en", 32'(wr_en), 0);
      req_data[0] = 16'h0F0F;
      req         = 4'b1001;
      @(negedge clk);
      check_eq("ovf_wait_full", 32'(wr_en), 0);
      full = 1'b0;
      @(negedge clk);
      check_eq("reissue_wr_en", 32'(wr_en), 1);
      check_eq("reissue_data", 32'(data_in), 32'h3C3C);
      @(negedge clk);
      wr_ack = 1'b1;
      #1;
      check_eq("reissue_gnt", 32'(gnt), 32'h8);
      check_eq("reissue_err", 32'(err), 0);
      req = 4'b0001;
      @(negedge clk);
      wr_ack = 1'b0;

      // Missing response: err set and sticky
      @(negedge clk);
      check_eq("noresp_wr_en", 32'(wr_en), 1);
      check_eq("noresp_data", 32'(data_in), 32'h0F0F);
      @(negedge clk);
      #1;
      check_eq("noresp_gnt", 32'(gnt), 0);
      @(negedge clk);
      check_eq("noresp_err", 32'(err), 1);
      check_eq("noresp_retry_cnt", 32'(retry_cnt), 1);
      check_eq("noresp_retry_wr_en", 32'(wr_en), 0);
      @(negedge clk);
      check_eq("noresp_reissue", 32'(wr_en), 1);
      @(negedge clk);
      wr_ack = 1'b1;
      #1;
      check_eq("noresp_gnt_final", 32'(gnt), 32'h1);
      req = 4'b0000;
      @(negedge clk);
      wr_ack = 1'b0;
      check_eq("err_sticky", 32'(err), 1);

      // Reset during RESP
      req_data[1] = 16'h5555;
      req         = 4'b0010;
      @(negedge clk);
      check_eq("rst_mid_issue", 32'(wr_en), 1);
      @(negedge clk);
      wr_ack = 1'b1;
      rst_n  = 1'b0;
      #1;
      check_eq("rst_mid_gnt", 32'(gnt), 0);
      check_eq("rst_mid_wr_en", 32'(wr_en), 0);
      check_eq("rst_mid_retry", 32'(retry_cnt), 0);
      check_eq("rst_mid_err", 32'(err), 0);
      check_eq("rst_mid_data", 32'(data_in), 0);
      wr_ack   = 1'b0;
      req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      req      = 4'b1111;
      @(negedge clk);
      rst_n = 1'b1;

      // All producers requesting: order 0,1,2,3,0, three cycles apart
      prev_en = 1'b0;
      last_c  = 0;
      ngnt    = 0;
      for (int c = 0; c < 40 && ngnt < 5; c++) begin
         @(negedge clk);
         wr_ack = prev_en;
         #1;
         if (gnt != 4'b0000) begin
            check_eq("rr_order", 32'(gnt), 32'(1) << (ngnt % 4));
            if (ngnt > 0) check_eq("rr_gap", 32'(c - last_c), 3);
            last_c = c;
            ngnt++;
         end
         prev_en = wr_en;
      end
      check_eq("rr_count", 32'(ngnt), 5);
      wr_ack = 1'b0;
      req    = 4'b0000;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
